// File: rtl/smi_fifo_byte_reader.sv
// Pops I/Q words from an FWFT FIFO and serialises them MSB-byte-first onto the SMI bus,
// one byte per synchronised host read strobe. Optional underrun counter: SMI_UNDERRUN_CNT_EN.
module smi_fifo_byte_reader #(
  parameter int                        DATA_WIDTH  = 16,
  parameter int                        SYNC_STAGES = 2,
  parameter logic [2*DATA_WIDTH-1:0]   FILL_WORD   = '0
) (
  input  logic                        clk_i,
  input  logic                        rst_i,
  input  logic                        channel_en_i,
  input  logic                        fifo_empty_i,
  input  logic [2*DATA_WIDTH-1:0]     fifo_data_i,
  output logic                        fifo_rd_en_o,
  input  logic                        smi_soe_b_i,
  output logic [7:0]                  smi_data_o,
  output logic                        word_start_o,
  output logic                        underrun_o
`ifdef SMI_UNDERRUN_CNT_EN
  ,
  output logic [15:0]                 underrun_cnt_o
`endif
);

  localparam int WW = 2 * DATA_WIDTH;
  localparam int NB = WW / 8;
  localparam int IW = (NB > 2) ? $clog2(NB) : 1;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_sync_d;
  logic                   r_req;
  logic [IW-1:0]          r_idx;
  logic [WW-1:0]          r_shift;
  logic [7:0]             r_data;
  logic                   r_ws;
  logic                   r_rd;
  logic                   r_un;

  logic [IW-1:0]          w_idx_nxt;
  logic [WW-1:0]          w_shift_nxt;
  logic [7:0]             w_data_nxt;
  logic                   w_ws_nxt;
  logic                   w_rd_nxt;
  logic                   w_un_nxt;
  logic [WW-1:0]          w_shl;

  // Request is registered once after edge detection, giving SYNC_STAGES+2 clocks pin-to-data.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_sync   <= '1;
      r_sync_d <= 1'b1;
      r_req    <= 1'b0;
      r_idx    <= '0;
      r_shift  <= '0;
      r_data   <= 8'h00;
      r_ws     <= 1'b0;
      r_rd     <= 1'b0;
      r_un     <= 1'b0;
    end else begin
      r_sync   <= {r_sync[SYNC_STAGES-2:0], smi_soe_b_i};
      r_sync_d <= r_sync[SYNC_STAGES-1];
      r_req    <= r_sync_d & ~r_sync[SYNC_STAGES-1];
      r_idx    <= w_idx_nxt;
      r_shift  <= w_shift_nxt;
      r_data   <= w_data_nxt;
      r_ws     <= w_ws_nxt;
      r_rd     <= w_rd_nxt;
      r_un     <= w_un_nxt;
    end
  end

  assign w_shl = r_shift << {r_idx, 3'b000};

  always_comb begin
    w_idx_nxt   = r_idx;
    w_shift_nxt = r_shift;
    w_data_nxt  = r_data;
    w_ws_nxt    = r_ws;
    w_rd_nxt    = 1'b0;
    w_un_nxt    = 1'b0;
    if (!channel_en_i) begin
      w_idx_nxt = '0;
    end else if (r_req) begin
      if (r_idx == '0) begin
        // Word boundary: take the FIFO head, or the fill word if nothing is ready.
        if (!fifo_empty_i) begin
          w_shift_nxt = fifo_data_i;
          w_rd_nxt    = 1'b1;
        end else begin
          w_shift_nxt = FILL_WORD;
          w_un_nxt    = 1'b1;
        end
        w_data_nxt = w_shift_nxt[WW-1 -: 8];
        w_ws_nxt   = 1'b1;
        w_idx_nxt  = IW'(1);
      end else begin
        w_data_nxt = w_shl[WW-1 -: 8];
        w_ws_nxt   = 1'b0;
        w_idx_nxt  = (r_idx == IW'(NB - 1)) ? '0 : r_idx + 1'b1;
      end
    end
  end

  assign smi_data_o   = r_data;
  assign word_start_o = r_ws;
  assign fifo_rd_en_o = r_rd;
  assign underrun_o   = r_un;

`ifdef SMI_UNDERRUN_CNT_EN
  logic        r_en_d;
  logic [15:0] r_un_cnt;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_en_d   <= 1'b0;
      r_un_cnt <= '0;
    end else begin
      r_en_d <= channel_en_i;
      if (channel_en_i && !r_en_d)
        r_un_cnt <= '0;
      else if (r_un && r_un_cnt != 16'hFFFF)
        r_un_cnt <= r_un_cnt + 16'd1;
    end
  end

  assign underrun_cnt_o = r_un_cnt;
`endif

endmodule

// File: tb/tb_smi_fifo_byte_reader.sv
// Randomised self-checking bench for smi_fifo_byte_reader: a queue-based FIFO model feeds the
// DUT and a word/byte-position reference model predicts every byte, pop and underrun.
module tb_smi_fifo_byte_reader;

  localparam logic [31:0] FILL = 32'h0000_0000;

  // ---------------- clock / reset ----------------
  logic        clk = 1'b0;
  logic        rst_i;
  logic        channel_en_i;
  logic        fifo_empty_i;
  logic [31:0] fifo_data_i;
  logic        fifo_rd_en_o;
  logic        smi_soe_b_i;
  logic [7:0]  smi_data_o;
  logic        word_start_o;
  logic        underrun_o;
`ifdef SMI_UNDERRUN_CNT_EN
  logic [15:0] underrun_cnt_o;
`endif

  always #5 clk = ~clk;

  smi_fifo_byte_reader #(.DATA_WIDTH(16), .SYNC_STAGES(2), .FILL_WORD(FILL)) dut (
    .clk_i        (clk),
    .rst_i        (rst_i),
    .channel_en_i (channel_en_i),
    .fifo_empty_i (fifo_empty_i),
    .fifo_data_i  (fifo_data_i),
    .fifo_rd_en_o (fifo_rd_en_o),
    .smi_soe_b_i  (smi_soe_b_i),
    .smi_data_o   (smi_data_o),
    .word_start_o (word_start_o),
    .underrun_o   (underrun_o)
`ifdef SMI_UNDERRUN_CNT_EN
    ,
    .underrun_cnt_o (underrun_cnt_o)
`endif
  );

  // ---------------- scoreboard ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- FIFO model ----------------
  logic [31:0] fq[$];
  int pops_seen = 0;
  int un_seen   = 0;
  int pop_while_empty = 0;

  function automatic void refresh();
    fifo_empty_i = (fq.size() == 0);
    fifo_data_i  = (fq.size() == 0) ? 32'hDEAD_BEEF : fq[0];
  endfunction

  always @(negedge clk) begin
    if (fifo_rd_en_o) begin
      pops_seen++;
      if (fq.size() == 0) pop_while_empty++;
      else void'(fq.pop_front());
    end
    if (underrun_o) un_seen++;
    refresh();
  end

  task automatic push(input logic [31:0] w);
    fq.push_back(w);
    refresh();
  endtask

  // ---------------- reference model ----------------
  int          m_pos  = 0;
  logic [31:0] m_word = '0;
  logic [7:0]  m_data = 8'h00;
  logic        m_ws   = 1'b0;
  int          exp_pops = 0;
  int          exp_un   = 0;
  int          m_cnt    = 0;

  // One host read: strobe low, expect old data through clock 3, new data at clock 4.
  task automatic strobe(input string tag);
    logic [7:0] prev;
    logic       e_pop;
    logic       e_un;
    prev  = m_data;
    e_pop = 1'b0;
    e_un  = 1'b0;
    if (channel_en_i) begin
      if (m_pos == 0) begin
        if (fq.size() > 0) begin
          m_word = fq[0];
          e_pop  = 1'b1;
        end else begin
          m_word = FILL;
          e_un   = 1'b1;
        end
      end
      m_data = 8'((m_word >> (8 * (3 - m_pos))) & 32'hFF);
      m_ws   = (m_pos == 0);
      m_pos  = (m_pos + 1) % 4;
    end
    if (e_pop) exp_pops++;
    if (e_un) begin
      exp_un++;
      if (m_cnt < 65535) m_cnt++;
    end
    @(negedge clk);
    smi_soe_b_i = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check({tag, "_hold"}, {24'h0, smi_data_o}, {24'h0, prev});
    smi_soe_b_i = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_data"}, {24'h0, smi_data_o}, {24'h0, m_data});
    check({tag, "_ws"}, {31'h0, word_start_o}, {31'h0, m_ws});
    check({tag, "_pop"}, {31'h0, fifo_rd_en_o}, {31'h0, e_pop});
    check({tag, "_un"}, {31'h0, underrun_o}, {31'h0, e_un});
    @(posedge clk);
    #1;
    check({tag, "_pop_end"}, {31'h0, fifo_rd_en_o}, 32'h0);
    check({tag, "_un_end"}, {31'h0, underrun_o}, 32'h0);
`ifdef SMI_UNDERRUN_CNT_EN
    check({tag, "_cnt"}, {16'h0, underrun_cnt_o}, m_cnt);
`endif
    repeat ($urandom_range(2, 5)) @(posedge clk);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_i = 1'b1;
    repeat (3) @(negedge clk);
    rst_i  = 1'b0;
    m_pos  = 0;
    m_data = 8'h00;
    m_ws   = 1'b0;
    m_cnt  = 0;
    check("rst_data", {24'h0, smi_data_o}, 32'h0);
    check("rst_pop", {31'h0, fifo_rd_en_o}, 32'h0);
    check("rst_ws", {31'h0, word_start_o}, 32'h0);
    check("rst_un", {31'h0, underrun_o}, 32'h0);
`ifdef SMI_UNDERRUN_CNT_EN
    check("rst_cnt", {16'h0, underrun_cnt_o}, 32'h0);
`endif
  endtask

  task automatic disable_for(input int cycles);
    @(negedge clk);
    channel_en_i = 1'b0;
    m_pos = 0;
    repeat (cycles) @(negedge clk);
  endtask

  task automatic enable();
    @(negedge clk);
    if (!channel_en_i) m_cnt = 0;
    channel_en_i = 1'b1;
  endtask

  // ---------------- stimulus ----------------
  initial begin
    rst_i        = 1'b1;
    channel_en_i = 1'b0;
    smi_soe_b_i  = 1'b1;
    refresh();

    do_reset();
    enable();

    push(32'hA1B2C3D4);
    for (int i = 0; i < 4; i++) strobe("single");
    check("single_pops", pops_seen, 1);

    for (int i = 0; i < 4; i++) strobe("underrun");
    check("underrun_pulses", un_seen, 1);

    push(32'h11223344);
    push(32'h55667788);
    for (int i = 0; i < 8; i++) strobe("stream");
    check("stream_pops", pops_seen, 3);

    push(32'hAABBCCDD);
    strobe("dis_pre");
    strobe("dis_pre");
    disable_for(2);
    push(32'h01020304);
    strobe("dis_strobe");
    strobe("dis_strobe");
    enable();
    for (int i = 0; i < 4; i++) strobe("reenable");

    push(32'h0A0B0C0D);
    strobe("rstmid_pre");
    do_reset();
    push(32'hE0E1E2E3);
    for (int i = 0; i < 4; i++) strobe("after_rst");

    for (int i = 0; i < 60; i++) begin
      if ($urandom_range(0, 2) != 0) push($urandom);
      if ($urandom_range(0, 11) == 0) begin
        disable_for($urandom_range(1, 3));
        if ($urandom_range(0, 1) == 1) strobe("rand_dis");
        enable();
      end
      strobe("rand");
    end

    repeat (4) @(negedge clk);
    check("total_pops", pops_seen, exp_pops);
    check("total_underruns", un_seen, exp_un);
    check("pop_while_empty", pop_while_empty, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/smi_fifo_byte_reader.md
Name: smi_fifo_byte_reader

Overview:
- Consumer stage on the read side of the I/Q async FWFT FIFO. Pops one 2*DATA_WIDTH-bit I/Q word and serialises it MSB-byte-first onto the 8-bit SMI bus.
- Each byte is paced by the host's active-low read strobe, which is resynchronised into clk_i.
- Substitutes a fill word on underrun and never pops an empty FIFO.

Parameters:
- DATA_WIDTH, 16: half-word width; FIFO word is 2*DATA_WIDTH bits (32).
- SYNC_STAGES, 2: flops in the smi_soe_b_i synchroniser (min 2).
- FILL_WORD, 32'h0000_0000: word emitted when the FIFO is empty at word start.

Ports:
- clk_i, input, 1: block clock; same clock as the FIFO read side.
- rst_i, input, 1: synchronous active-high reset.
- channel_en_i, input, 1: streaming enable.
- fifo_empty_i, input, 1: FIFO empty flag.
- fifo_data_i, input, 2*DATA_WIDTH: FWFT head word; valid while fifo_empty_i=0.
- fifo_rd_en_o, output, 1: one-cycle pop pulse.
- smi_soe_b_i, input, 1: asynchronous active-low SMI read strobe.
- smi_data_o, output, 8: byte presented to the host.
- word_start_o, output, 1: high while byte 0 of a word is on smi_data_o.
- underrun_o, output, 1: one-cycle pulse when FILL_WORD is substituted.

Behaviour:
- Reset values: smi_data_o=8'h00, fifo_rd_en_o=0, word_start_o=0, underrun_o=0, byte_idx=0, shift reg=0. Synchroniser flops reset to 1 (strobe inactive).
- Strobe request: smi_soe_b_i passes through SYNC_STAGES flops. req = previous sync value 1 AND current sync value 0 (falling edge), one cycle wide.
- Latency: a strobe edge on the pin gives a new smi_data_o SYNC_STAGES+2 clocks later (4 at default). smi_data_o holds its value between requests.
- State is byte_idx, 0..NB-1, where NB = 2*DATA_WIDTH/8 = 4.

On req with channel_en_i=1:
- byte_idx=0, fifo_empty_i=0:
  - shift <= fifo_data_i; smi_data_o <= fifo_data_i[31:24].
  - fifo_rd_en_o=1 for exactly this cycle.
  - word_start_o<=1; byte_idx<=1.
- byte_idx=0, fifo_empty_i=1:
  - shift <= FILL_WORD; smi_data_o <= FILL_WORD[31:24].
  - No pop; underrun_o=1 for one cycle.
  - word_start_o<=1; byte_idx<=1.
- byte_idx=k>0:
  - smi_data_o <= shift byte (NB-1-k), i.e. bits [31-8k -: 8].
  - word_start_o<=0; byte_idx<=k+1, wrapping to 0 after NB-1.

Other rules:
- No req: all outputs hold, except fifo_rd_en_o and underrun_o, which return to 0.
- Pop rule: at most one pop per NB requests, and only at byte_idx=0. fifo_rd_en_o is never asserted while fifo_empty_i=1.
- The FIFO's empty flag updates the cycle after a pop. Requests are at least SYNC_STAGES+1 cycles apart, so this needs no special handling.
- channel_en_i=0: byte_idx<=0 immediately (a partial word is discarded), req is ignored, no pops, smi_data_o holds.
- Re-enabling always starts at a word boundary.
- rst_i mid-word: all state returns to reset values on the next edge. The already-popped word is lost.
- Back-to-back edges closer than SYNC_STAGES+1 cycles are outside the contract; one of them may be missed.

Optional Feature:
- Macro SMI_UNDERRUN_CNT_EN.
- Defined:
  - Adds output port underrun_cnt_o [15:0].
  - Increments by 1 on each underrun_o pulse and saturates at 16'hFFFF.
  - Cleared by rst_i, and by channel_en_i rising (0 in the previous cycle, 1 in the current one).
- Undefined: the port and counter do not exist; all other behaviour is identical.

Test Plan:
- Reset:
  - Stimulus: rst_i=1 for 3 cycles with smi_soe_b_i=1.
  - Response: smi_data_o=00, fifo_rd_en_o=0, word_start_o=0, underrun_o=0; counter=0 if enabled.
- Single word:
  - Stimulus: FIFO head 32'hA1B2C3D4, non-empty; 4 strobe pulses spaced 8 clocks.
  - Response: bytes A1,B2,C3,D4 in order; exactly one fifo_rd_en_o pulse, on the first byte; word_start_o only with A1.
- Underrun:
  - Stimulus: fifo_empty_i=1, FILL_WORD=32'h0, 4 strobes.
  - Response: bytes 00,00,00,00; one underrun_o pulse; no fifo_rd_en_o.
  - With SMI_UNDERRUN_CNT_EN: counter=1.
  - After 65540 underrun words: counter=FFFF.
- Stream:
  - Stimulus: words 11223344 then 55667788; 8 strobes.
  - Response: 11,22,33,44,55,66,77,88; 2 pops, spaced 4 requests apart.
  - Strobe-to-data latency measured as exactly 4 clocks.
- Disable mid-word:
  - Stimulus: after 2 bytes of AABBCCDD, channel_en_i=0 for 2 cycles then 1; head now 01020304; 4 strobes.
  - Response: 01,02,03,04.
  - Strobes while disabled: no data change, no pop.
- Reset mid-word:
  - Stimulus: rst_i pulse after byte 1 of 0A0B0C0D; next head E0E1E2E3.
  - Response: the next 4 strobes give E0,E1,E2,E3 with word_start_o on E0.
